spi_master: RTL

// - Single-byte SPI master; drives cs/sck/mosi toward an SPI slave port and captures miso.
// - Mode: sck idles high; mosi changes on sck falling edge; slave samples on rising edge;

---
 rtl/spi_master_pkg.sv | 26 ++
 rtl/spi_master_if.sv | 21 ++
 rtl/spi_tick_cnt.sv | 34 +++
 rtl/spi_master.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared definitions for the single-byte SPI master: FSM state encoding,
// CPOL=1 idle level, default timing constants and a counter sizing helper.
package spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  localparam logic CPOL_IDLE = 1'b1;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_CS_SETUP = 4;
  localparam int DEF_CS_HOLD  = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Local controller handshake between a requester and the SPI master:
// start/tx_data in, ready/rx_data/rx_valid back.
interface spi_master_if;

  logic       start;
  logic [7:0] tx_data;
  logic       ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (
    output start, tx_data,
    input  ready, rx_data, rx_valid
  );

  modport slave (
    input  start, tx_data,
    output ready, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_tick_cnt.sv
// Loadable down-counter; done_o is high while the count sits at zero.
// Loading N-1 on state entry makes that state last exactly N cycles.
module spi_tick_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI master, sck idle high, MSB first, miso sampled at end of sck-high.
// Optional SPI_MASTER_BURST_EN: back-to-back bytes under one cs low window.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.slave  ctrl,
  output logic         cs_o,
  output logic         sck_o,
  output logic         mosi_o,
  input  logic         miso_i
);

  localparam int CNT_W = $clog2(max3(CLK_DIV, CS_SETUP, CS_HOLD) + 1);
  localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);

  spi_state_e state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       cs_q, cs_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [1:0] miso_sync_q;

  logic             tick_load;
  logic [CNT_W-1:0] tick_load_val;
  logic             tick_done;
  logic             ready;
  logic             enter_low;
  logic [7:0]       low_byte;
  logic             finish_byte;

  spi_tick_cnt #(.W(CNT_W)) u_tick_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tick_load),
    .load_val_i (tick_load_val),
    .done_o     (tick_done)
  );

  // Each state reloads the shared counter on entry; enter_low and finish_byte
  // collect the actions shared by several transitions.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    rx_shift_d    = rx_shift_q;
    bit_cnt_d     = bit_cnt_q;
    cs_d          = cs_q;
    sck_d         = sck_q;
    mosi_d        = mosi_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tick_load     = 1'b0;
    tick_load_val = '0;
    ready         = 1'b0;
    enter_low     = 1'b0;
    low_byte      = shift_q;
    finish_byte   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (ctrl.start) begin
          shift_d       = ctrl.tx_data;
          bit_cnt_d     = 3'd7;
          cs_d          = 1'b0;
          tick_load     = 1'b1;
          tick_load_val = SETUP_LD;
          state_d       = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick_done) begin
          enter_low = 1'b1;
        end
      end
      ST_LOW: begin
        if (tick_done) begin
          sck_d         = 1'b1;
          tick_load     = 1'b1;
          tick_load_val = DIV_LD;
          state_d       = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (tick_done) begin
          rx_shift_d = {rx_shift_q[6:0], miso_sync_q[1]};
          if (bit_cnt_q == 3'd0) begin
            tick_load     = 1'b1;
            tick_load_val = HOLD_LD;
            state_d       = ST_HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            enter_low = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (tick_done) begin
          finish_byte = 1'b1;
`ifdef SPI_MASTER_BURST_EN
          ready = 1'b1;
          if (ctrl.start) begin
            bit_cnt_d = 3'd7;
            low_byte  = ctrl.tx_data;
            enter_low = 1'b1;
          end else begin
            cs_d          = 1'b1;
            mosi_d        = 1'b1;
            tick_load     = 1'b1;
            tick_load_val = HOLD_LD;
            state_d       = ST_GAP;
          end
`else
          cs_d          = 1'b1;
          mosi_d        = 1'b1;
          tick_load     = 1'b1;
          tick_load_val = HOLD_LD;
          state_d       = ST_GAP;
`endif
        end
      end
      ST_GAP: begin
        if (tick_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_low) begin
      sck_d         = 1'b0;
      mosi_d        = low_byte[7];
      shift_d       = {low_byte[6:0], 1'b0};
      tick_load     = 1'b1;
      tick_load_val = DIV_LD;
      state_d       = ST_LOW;
    end

    if (finish_byte) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      rx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      cs_q        <= 1'b1;
      sck_q       <= CPOL_IDLE;
      mosi_q      <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      rx_shift_q  <= rx_shift_d;
      bit_cnt_q   <= bit_cnt_d;
      cs_q        <= cs_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_sync_q <= {miso_sync_q[0], miso_i};
    end
  end

  assign ctrl.ready    = ready;
  assign ctrl.rx_data  = rx_data_q;
  assign ctrl.rx_valid = rx_valid_q;
  assign cs_o          = cs_q;
  assign sck_o         = sck_q;
  assign mosi_o        = mosi_q;

endmodule
